// File: rtl/alarm_bank_if.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_bank_if
//  Description : Signal bundle between the timekeeping/control side and the
//                alarm bank. The master drives time, tick and command inputs
//                and observes the alarm outputs; the slave is the alarm bank.
//  Ports       : none (clk/resetN are plain ports of the alarm bank)
//                tick1s                              1 Hz single-cycle pulse
//                curHour1/curHour0/curMin1/curMin0   current BCD time
//                setEn/clrEn/setIdx                  channel programming
//                setHour1/setHour0/setMin1/setMin0   BCD time to program
//                snooze/dismiss                      user pulses
//                alarm/ringing/snoozed               status outputs
//  Revision    : 1.0 - initial release
// ============================================================================
interface alarm_bank_if #(
   parameter int NUM_ALARMS = 4,
   parameter int IDX_W      = 2
) ();
   logic                  tick1s;
   logic [3:0]            curHour1;
   logic [3:0]            curHour0;
   logic [3:0]            curMin1;
   logic [3:0]            curMin0;
   logic                  setEn;
   logic [IDX_W-1:0]      setIdx;
   logic [3:0]            setHour1;
   logic [3:0]            setHour0;
   logic [3:0]            setMin1;
   logic [3:0]            setMin0;
   logic                  clrEn;
   logic                  snooze;
   logic                  dismiss;
   logic                  alarm;
   logic [NUM_ALARMS-1:0] ringing;
   logic [NUM_ALARMS-1:0] snoozed;

   modport master (
      output tick1s, curHour1, curHour0, curMin1, curMin0,
      output setEn, setIdx, setHour1, setHour0, setMin1, setMin0,
      output clrEn, snooze, dismiss,
      input  alarm, ringing, snoozed
   );

   modport slave (
      input  tick1s, curHour1, curHour0, curMin1, curMin0,
      input  setEn, setIdx, setHour1, setHour0, setMin1, setMin0,
      input  clrEn, snooze, dismiss,
      output alarm, ringing, snoozed
   );
endinterface
`default_nettype wire

// File: rtl/alarm_bank.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_bank
//  Description : NUM_ALARMS independent BCD alarm channels. Each channel rings
//                when the current time enters its programmed minute, can be
//                snoozed (SNOOZE_MIN minutes, at most SNOOZE_MAX times per ring
//                episode), dismissed, and stops by itself after RING_TICKS
//                one-second ticks.
//  Ports       : clk      system clock
//                resetN   synchronous active-low reset
//                bus      alarm_bank_if.slave (time, tick, commands, status)
//  Revision    : 1.0 - initial release
// ============================================================================
module alarm_bank #(
   parameter int NUM_ALARMS = 4,
   parameter int IDX_W      = 2,
   parameter int RING_TICKS = 60,
   parameter int SNOOZE_MIN = 5,
   parameter int SNOOZE_MAX = 3
) (
   input  wire logic   clk,
   input  wire logic   resetN,
   alarm_bank_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARMED   = 2'd1,
      S_RINGING = 2'd2,
      S_SNOOZED = 2'd3
   } state_t;

   // Snooze increment split into BCD digits so the add stays in BCD.
   localparam logic [3:0] c_SN_TENS   = 4'(SNOOZE_MIN / 10);
   localparam logic [3:0] c_SN_ONES   = 4'(SNOOZE_MIN % 10);
   localparam logic [7:0] c_RING_LAST = 8'(RING_TICKS - 1);
   localparam logic [3:0] c_SNZ_MAX   = 4'(SNOOZE_MAX);

   // ------------------------------------------------------------------------
   // Minute-event detection. The previous-time register follows the input
   // every cycle, including during reset, so leaving reset never produces a
   // spurious event. Any change (normal roll-over or a time jump) is an event.
   // ------------------------------------------------------------------------
   logic [15:0] w_cur;
   logic [15:0] r_prev;
   logic        w_min_evt;

   assign w_cur     = {bus.curHour1, bus.curHour0, bus.curMin1, bus.curMin0};
   assign w_min_evt = (w_cur != r_prev);

   always_ff @(posedge clk) begin
      r_prev <= w_cur;
   end

   // ------------------------------------------------------------------------
   // Snooze target = current time + SNOOZE_MIN, modulo 24:00, in BCD.
   // Shared by all channels since every snoozing channel uses the same time.
   // ------------------------------------------------------------------------
   logic [4:0]  w_mo_sum;
   logic        w_mo_cy;
   logic [3:0]  w_mo;
   logic [4:0]  w_mt_sum;
   logic        w_mt_cy;
   logic [3:0]  w_mt;
   logic [4:0]  w_ho_sum;
   logic        w_ho_cy;
   logic [3:0]  w_ho;
   logic [3:0]  w_ht;
   logic        w_day_wrap;
   logic [15:0] w_snz_target;

   assign w_mo_sum = {1'b0, bus.curMin0} + {1'b0, c_SN_ONES};
   assign w_mo_cy  = (w_mo_sum >= 5'd10);
   assign w_mo     = w_mo_cy ? 4'(w_mo_sum - 5'd10) : w_mo_sum[3:0];

   assign w_mt_sum = {1'b0, bus.curMin1} + {1'b0, c_SN_TENS} + {4'b0, w_mo_cy};
   assign w_mt_cy  = (w_mt_sum >= 5'd6);
   assign w_mt     = w_mt_cy ? 4'(w_mt_sum - 5'd6) : w_mt_sum[3:0];

   assign w_ho_sum = {1'b0, bus.curHour0} + {4'b0, w_mt_cy};
   assign w_ho_cy  = (w_ho_sum >= 5'd10);
   assign w_ho     = w_ho_cy ? 4'(w_ho_sum - 5'd10) : w_ho_sum[3:0];
   assign w_ht     = bus.curHour1 + {3'b0, w_ho_cy};

   // 23:xx plus a carry lands on 24:xx, which folds back to 00:xx.
   assign w_day_wrap   = ({w_ht, w_ho} == 8'h24);
   assign w_snz_target = w_day_wrap ? {8'h00, w_mt, w_mo} : {w_ht, w_ho, w_mt, w_mo};

   logic [15:0] w_set_time;
   assign w_set_time = {bus.setHour1, bus.setHour0, bus.setMin1, bus.setMin0};

   // ------------------------------------------------------------------------
   // Per-channel state machines.
   // ------------------------------------------------------------------------
   logic [NUM_ALARMS-1:0] w_ringing;
   logic [NUM_ALARMS-1:0] w_snoozed;

   for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_ch
      state_t      r_state;
      logic [15:0] r_alm_time;
      logic [15:0] r_snz_time;
      logic [3:0]  r_snz_cnt;
      logic [7:0]  r_ring_cnt;
      logic        r_ring;
      logic        r_snzd;
      logic        w_sel;

      // An index outside the channel range matches no channel, so such
      // commands fall through harmlessly.
      assign w_sel = (32'(bus.setIdx) == gi);

      always_ff @(posedge clk) begin
         if (!resetN) begin
            r_state    <= S_IDLE;
            r_alm_time <= 16'h0000;
            r_snz_time <= 16'h0000;
            r_snz_cnt  <= 4'd0;
            r_ring_cnt <= 8'd0;
            r_ring     <= 1'b0;
            r_snzd     <= 1'b0;
         end else if (bus.clrEn && w_sel) begin
            r_state    <= S_IDLE;
            r_alm_time <= 16'h0000;
            r_snz_cnt  <= 4'd0;
            r_ring_cnt <= 8'd0;
            r_ring     <= 1'b0;
            r_snzd     <= 1'b0;
         end else if (bus.setEn && w_sel) begin
            // Programming the current minute never rings now: the event for
            // this minute has already passed, so the next match is tomorrow.
            r_state    <= S_ARMED;
            r_alm_time <= w_set_time;
            r_snz_cnt  <= 4'd0;
            r_ring_cnt <= 8'd0;
            r_ring     <= 1'b0;
            r_snzd     <= 1'b0;
         end else begin
            case (r_state)
               S_ARMED: begin
                  if (w_min_evt && (w_cur == r_alm_time)) begin
                     r_state    <= S_RINGING;
                     r_ring_cnt <= 8'd0;
                     r_snz_cnt  <= 4'd0;
                     r_ring     <= 1'b1;
                  end
               end
               S_RINGING: begin
                  if (bus.dismiss) begin
                     r_state   <= S_ARMED;
                     r_snz_cnt <= 4'd0;
                     r_ring    <= 1'b0;
                  end else if (bus.snooze && (r_snz_cnt < c_SNZ_MAX)) begin
                     // Snooze beats a timeout landing in the same cycle.
                     r_state    <= S_SNOOZED;
                     r_snz_cnt  <= r_snz_cnt + 4'd1;
                     r_snz_time <= w_snz_target;
                     r_ring     <= 1'b0;
                     r_snzd     <= 1'b1;
                  end else if (bus.tick1s) begin
                     if (r_ring_cnt == c_RING_LAST) begin
                        r_state    <= S_ARMED;
                        r_snz_cnt  <= 4'd0;
                        r_ring_cnt <= 8'd0;
                        r_ring     <= 1'b0;
                     end else begin
                        r_ring_cnt <= r_ring_cnt + 8'd1;
                     end
                  end
               end
               S_SNOOZED: begin
                  if (bus.dismiss) begin
                     r_state   <= S_ARMED;
                     r_snz_cnt <= 4'd0;
                     r_snzd    <= 1'b0;
                  end else if (w_min_evt && (w_cur == r_snz_time)) begin
                     // Snooze count survives so the limit spans the episode.
                     r_state    <= S_RINGING;
                     r_ring_cnt <= 8'd0;
                     r_ring     <= 1'b1;
                     r_snzd     <= 1'b0;
                  end
               end
               S_IDLE: begin
                  r_ring <= 1'b0;
                  r_snzd <= 1'b0;
               end
               default: begin
                  r_state <= S_IDLE;
                  r_ring  <= 1'b0;
                  r_snzd  <= 1'b0;
               end
            endcase
         end
      end

      assign w_ringing[gi] = r_ring;
      assign w_snoozed[gi] = r_snzd;
   end

   assign bus.ringing = w_ringing;
   assign bus.snoozed = w_snoozed;
   assign bus.alarm   = |w_ringing;

endmodule
`default_nettype wire

// File: tb/tb_alarm_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alarm_bank
//  Description : Directed stimulus for alarm_bank. Each stimulus step queues
//                the hand-derived status expected after the next clock edge;
//                an independent monitor compares it on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_bank;

   localparam int NUM_ALARMS = 4;
   localparam int IDX_W      = 2;

   logic clk;
   logic resetN;
   int   cyc;

   alarm_bank_if #(.NUM_ALARMS(NUM_ALARMS), .IDX_W(IDX_W)) bus ();

   alarm_bank #(
      .NUM_ALARMS(NUM_ALARMS),
      .IDX_W     (IDX_W),
      .RING_TICKS(60),
      .SNOOZE_MIN(5),
      .SNOOZE_MAX(3)
   ) dut (
      .clk   (clk),
      .resetN(resetN),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         at;
      logic [3:0] ring;
      logic [3:0] snz;
      logic       alm;
      string      name;
   } exp_t;

   exp_t sb[$];
   exp_t m_e;
   int   n_checks;
   int   n_fail;

   initial begin
      n_checks = 0;
      n_fail   = 0;
   end

   // Monitor: compares the head entry when its cycle comes up.
   always @(negedge clk) begin
      if (sb.size() > 0 && sb[0].at <= cyc) begin
         m_e = sb.pop_front();
         n_checks = n_checks + 1;
         if (m_e.at != cyc) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: check slot missed (due cycle %0d, now %0d)", m_e.name, m_e.at, cyc);
         end else if ({bus.alarm, bus.ringing, bus.snoozed} !== {m_e.alm, m_e.ring, m_e.snz}) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got alarm=%b ringing=%b snoozed=%b, want alarm=%b ringing=%b snoozed=%b",
                     m_e.name, bus.alarm, bus.ringing, bus.snoozed, m_e.alm, m_e.ring, m_e.snz);
         end
      end
   end

   // Expected status after the next rising edge.
   task automatic push_exp(input logic [3:0] r, input logic [3:0] s, input string nm);
      exp_t e;
      e.at   = cyc + 1;
      e.ring = r;
      e.snz  = s;
      e.alm  = |r;
      e.name = nm;
      sb.push_back(e);
   endtask

   // Advance to the next falling edge and drop all single-cycle pulses.
   task automatic step_cyc();
      @(negedge clk);
      bus.setEn   = 1'b0;
      bus.clrEn   = 1'b0;
      bus.snooze  = 1'b0;
      bus.dismiss = 1'b0;
      bus.tick1s  = 1'b0;
   endtask

   task automatic set_time(input int hh, input int mm);
      bus.curHour1 = 4'(hh / 10);
      bus.curHour0 = 4'(hh % 10);
      bus.curMin1  = 4'(mm / 10);
      bus.curMin0  = 4'(mm % 10);
   endtask

   task automatic prog(input int idx, input int hh, input int mm);
      bus.setEn    = 1'b1;
      bus.setIdx   = IDX_W'(idx);
      bus.setHour1 = 4'(hh / 10);
      bus.setHour0 = 4'(hh % 10);
      bus.setMin1  = 4'(mm / 10);
      bus.setMin0  = 4'(mm % 10);
   endtask

   initial begin
      resetN      = 1'b0;
      bus.setEn   = 1'b0;
      bus.clrEn   = 1'b0;
      bus.snooze  = 1'b0;
      bus.dismiss = 1'b0;
      bus.tick1s  = 1'b0;
      bus.setIdx  = '0;
      bus.setHour1 = 4'd0;
      bus.setHour0 = 4'd0;
      bus.setMin1  = 4'd0;
      bus.setMin0  = 4'd0;
      set_time(0, 0);

      // Reset state
      step_cyc(); push_exp(4'b0000, 4'b0000, "reset");
      step_cyc(); resetN = 1'b1; push_exp(4'b0000, 4'b0000, "idle_after_reset");

      // Ch0 at 07:30, then ring timeout after 60 ticks
      step_cyc(); prog(0, 7, 30); set_time(7, 29); push_exp(4'b0000, 4'b0000, "ch0_armed");
      step_cyc(); set_time(7, 30); push_exp(4'b0001, 4'b0000, "ch0_ring");
      for (int i = 0; i < 60; i++) begin
         step_cyc(); bus.tick1s = 1'b1;
         push_exp((i == 59) ? 4'b0000 : 4'b0001, 4'b0000, (i == 59) ? "ch0_timeout" : "ch0_ringing_tick");
         step_cyc();
      end
      step_cyc(); set_time(7, 29); push_exp(4'b0000, 4'b0000, "ch0_quiet");
      step_cyc(); set_time(7, 30); push_exp(4'b0001, 4'b0000, "ch0_rearmed_ring");
      step_cyc(); bus.dismiss = 1'b1; push_exp(4'b0000, 4'b0000, "ch0_dismiss");

      // Ch1 at 23:58, snooze across midnight to 00:03
      step_cyc(); prog(1, 23, 58); set_time(23, 57); push_exp(4'b0000, 4'b0000, "ch1_armed");
      step_cyc(); set_time(23, 58); push_exp(4'b0010, 4'b0000, "ch1_ring");
      step_cyc(); bus.snooze = 1'b1; push_exp(4'b0000, 4'b0010, "ch1_snoozed");
      step_cyc(); set_time(23, 59); push_exp(4'b0000, 4'b0010, "ch1_snz_2359");
      step_cyc(); set_time(0, 0);   push_exp(4'b0000, 4'b0010, "ch1_snz_0000");
      step_cyc(); set_time(0, 2);   push_exp(4'b0000, 4'b0010, "ch1_snz_0002");
      step_cyc(); set_time(0, 3);   push_exp(4'b0010, 4'b0000, "ch1_ring_0003");
      step_cyc(); bus.snooze = 1'b1; push_exp(4'b0000, 4'b0010, "ch1_snoozed2");
      step_cyc(); bus.dismiss = 1'b1; push_exp(4'b0000, 4'b0000, "ch1_dismiss_snoozed");
      step_cyc(); set_time(0, 8);   push_exp(4'b0000, 4'b0000, "ch1_no_ring_0008");

      // Ch2 snooze limit: three snoozes honoured, fourth ignored
      step_cyc(); prog(2, 6, 0); set_time(5, 59); push_exp(4'b0000, 4'b0000, "ch2_armed");
      step_cyc(); set_time(6, 0); push_exp(4'b0100, 4'b0000, "ch2_ring");
      for (int k = 1; k <= 3; k++) begin
         step_cyc(); bus.snooze = 1'b1; push_exp(4'b0000, 4'b0100, "ch2_snoozed");
         step_cyc(); set_time(6, 5 * k); push_exp(4'b0100, 4'b0000, "ch2_rering");
      end
      step_cyc(); bus.snooze = 1'b1; push_exp(4'b0100, 4'b0000, "ch2_snooze_ignored");
      step_cyc(); bus.dismiss = 1'b1; push_exp(4'b0000, 4'b0000, "ch2_dismiss");

      // Ch0 and ch3 at 12:00 together, single dismiss
      step_cyc(); prog(0, 12, 0); set_time(11, 59); push_exp(4'b0000, 4'b0000, "ch0_set_1200");
      step_cyc(); prog(3, 12, 0); push_exp(4'b0000, 4'b0000, "ch3_set_1200");
      step_cyc(); set_time(12, 0); push_exp(4'b1001, 4'b0000, "ch0_ch3_ring");
      step_cyc(); bus.dismiss = 1'b1; push_exp(4'b0000, 4'b0000, "ch0_ch3_dismiss");

      // Programming the current minute, then clrEn beating setEn
      step_cyc(); set_time(10, 15); push_exp(4'b0000, 4'b0000, "time_1015");
      step_cyc(); prog(1, 10, 15); push_exp(4'b0000, 4'b0000, "ch1_set_now");
      step_cyc(); push_exp(4'b0000, 4'b0000, "ch1_no_ring_same_min");
      step_cyc(); prog(1, 10, 16); bus.clrEn = 1'b1; push_exp(4'b0000, 4'b0000, "ch1_clr_set");
      step_cyc(); set_time(10, 16); push_exp(4'b0000, 4'b0000, "ch1_clr_wins");

      // Reset in the middle of a ring
      step_cyc(); prog(0, 8, 0); set_time(7, 59); push_exp(4'b0000, 4'b0000, "ch0_set_0800");
      step_cyc(); set_time(8, 0); push_exp(4'b0001, 4'b0000, "ch0_ring_0800");
      step_cyc(); resetN = 1'b0; push_exp(4'b0000, 4'b0000, "reset_mid_ring");
      step_cyc(); resetN = 1'b1; push_exp(4'b0000, 4'b0000, "post_reset");
      step_cyc(); set_time(23, 59); push_exp(4'b0000, 4'b0000, "post_reset_2359");
      step_cyc(); set_time(0, 0);   push_exp(4'b0000, 4'b0000, "no_ring_0000");
      step_cyc(); set_time(7, 59);  push_exp(4'b0000, 4'b0000, "post_reset_0759");
      step_cyc(); set_time(8, 0);   push_exp(4'b0000, 4'b0000, "ch0_idle_0800");

      // Let the monitor drain, bounded
      for (int w = 0; w < 5 && sb.size() > 0; w++) step_cyc();
      if (sb.size() > 0) begin
         n_checks = n_checks + 1;
         n_fail   = n_fail + 1;
         $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/alarm_bank.md
Name: alarm_bank

Overview:
Multi-channel alarm controller for the watch datapath. It holds NUM_ALARMS independently programmable BCD alarm times. Each channel rings on minute-entry match, supports snooze with BCD time arithmetic and a snooze limit, and has a tick-based ring timeout. It sits beside the timekeeping counter, takes the BCD time digits plus a 1 Hz tick, and drives the buzzer/LED logic.

Parameters:
NUM_ALARMS, 4, number of alarm channels (1..8)
IDX_W, 2, width of channel index, >= clog2(NUM_ALARMS)
RING_TICKS, 60, ring duration in tick1s pulses before auto-stop (1..255)
SNOOZE_MIN, 5, minutes added per snooze (1..59)
SNOOZE_MAX, 3, snoozes allowed per ring episode (0..15)

Ports:
clk  in  1  system clock
resetN  in  1  synchronous active-low reset
tick1s  in  1  one-cycle pulse per second
curHour1, curHour0, curMin1, curMin0  in  4 each  current time, valid BCD 00:00-23:59
setEn  in  1  program channel setIdx with setHour1/setHour0/setMin1/setMin0 and enable it
setIdx  in  IDX_W  target channel for setEn/clrEn
setHour1, setHour0, setMin1, setMin0  in  4 each  alarm time to program (BCD)
clrEn  in  1  disable channel setIdx and clear its time to 00:00
snooze  in  1  one-cycle pulse: snooze all RINGING channels
dismiss  in  1  one-cycle pulse: stop all RINGING and SNOOZED channels
alarm  out  1  OR of ringing
ringing  out  NUM_ALARMS  per-channel RINGING flag
snoozed  out  NUM_ALARMS  per-channel SNOOZED flag

Behaviour:
- Reset (resetN=0 at posedge): all channels IDLE, times 00:00, snooze counts 0, ring counters 0, all outputs 0. The previous-time register loads the current inputs, so no spurious minute event occurs after reset.
- Minute event: in cycle T, the registered previous time differs from the current {curHour1..curMin0}. The previous-time register updates every cycle.
- Per-channel FSM states: IDLE, ARMED, RINGING, SNOOZED. Outputs are registered.
- IDLE: setEn on this channel -> ARMED. No other exits.
- ARMED: minute event with current time == alarm time -> RINGING. The ringing bit is high from T+1. Ring counter and snooze count are cleared on entry.
- Programming a channel to the current minute does not ring until the next minute entry (next day).
- RINGING: ring counter increments on each tick1s. On the RING_TICKS-th tick after entry -> ARMED, snooze count cleared.
- RINGING + snooze with snooze count < SNOOZE_MAX -> SNOOZED. Count increments. Snooze target = (current time + SNOOZE_MIN) mod 24:00, computed in BCD with minute carry into the hour and 23:xx wrapping to 00:xx.
- RINGING + snooze with count == SNOOZE_MAX: ignored, channel keeps ringing.
- SNOOZED: minute event with current time == snooze target -> RINGING. Ring counter is cleared; snooze count is kept.
- dismiss: RINGING or SNOOZED -> ARMED, snooze count cleared. The channel rings again next day.
- Priority per channel, same cycle: clrEn > setEn > dismiss > snooze > minute-match > ring timeout.
- setEn on a RINGING/SNOOZED channel: new time loaded, state -> ARMED.
- clrEn on any state: -> IDLE.
- setEn and clrEn both asserted: clrEn wins.
- setIdx >= NUM_ALARMS: command ignored.
- Several channels matching the same minute all ring. snooze/dismiss apply to every eligible channel at once.
- A ring timeout on the same cycle as a snooze: snooze wins.
- Reset mid-ring or mid-snooze: immediate return to reset state.
- Input time jumps (time being set) count as minute events and can trigger matches.
- Non-BCD inputs: behaviour undefined, no lock-up required.

Test Plan:
- Ch0 set 07:30, time steps 07:29->07:30 -> ringing[0]=1 and alarm=1 one cycle after the change. 60 tick1s pulses later ringing[0]=0, ch0 ARMED.
- Ch1 set 23:58, ringing, snooze -> snoozed[1]=1, target 00:03. Time advances to 00:03 -> ringing[1]=1.
- Ch2 SNOOZE_MAX=3: ring, then snooze, ring three times. The 4th snooze is ignored and ringing[2] stays 1. dismiss -> ringing=0, snoozed=0.
- Ch0 and ch3 both set 12:00, time reaches 12:00 -> ringing=4'b1001. Single dismiss clears both.
- setEn ch1=10:15 while time is 10:15 -> no ring. clrEn and setEn same cycle on ch1 -> ch1 IDLE, time 00:00.
- resetN=0 for one cycle while ch0 is ringing -> all outputs 0 next cycle. The following minute match on 00:00 does not ring because all channels are IDLE.
